// File: rtl/wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wrr_arbiter
// Description : Weighted round-robin arbiter with registered grant outputs.
//               A grant is held under a valid/ack handshake. Each requester
//               may keep the grant for up to its weight of consecutive
//               accepted transfers before priority rotates past it.
// Revision    : 1.0 - initial release
// ============================================================================
module wrr_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int IW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    input  logic            ack,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_idx
);

    localparam logic [IW-1:0] c_LAST_IDX = IW'(N - 1);
    localparam logic [N-1:0]  c_ONE      = N'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    w_grant_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_ptr_nxt;
    logic [WW-1:0]   r_cnt;
    logic [WW-1:0]   w_cnt_nxt;

    logic [WW-1:0]   w_weight_arr [N];
    logic [WW-1:0]   w_wt_raw;
    logic [WW-1:0]   w_wt_eff;
    logic            w_more;
    logic            w_cur_req;
    logic [IW-1:0]   w_rot_ptr;
    logic [IW-1:0]   w_pick_base;
    logic [IW:0]     w_pick;
    logic            w_rearb;

    // Rotating first-set search: walks base, base+1, ..., N-1, 0, ..., base-1.
    // Iterating from the far end and overwriting leaves the nearest hit.
    function automatic logic [IW:0] f_pick(input logic [N-1:0] v,
                                           input logic [IW-1:0] base);
        logic [IW:0] res;
        int          pos;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(base) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (v[pos[IW-1:0]]) begin
                res = {1'b1, pos[IW-1:0]};
            end
        end
        return res;
    endfunction

    // Split the flat weight bus into one field per requester.
    for (genvar gi = 0; gi < N; gi++) begin : g_weight
        assign w_weight_arr[gi] = weight[gi*WW +: WW];
    end

    // A weight of zero behaves as one so every grant allows at least one transfer.
    assign w_wt_raw  = w_weight_arr[r_idx];
    assign w_wt_eff  = (w_wt_raw == '0) ? WW'(1) : w_wt_raw;
    // cnt+1 < w rewritten as cnt < w-1 to stay within WW bits.
    assign w_more    = (r_cnt < (w_wt_eff - WW'(1)));
    assign w_cur_req = req[r_idx];
    assign w_rot_ptr = (r_idx == c_LAST_IDX) ? '0 : (r_idx + IW'(1));

    // While granting, re-arbitration starts just past the current holder.
    assign w_pick_base = (r_state == ST_GRANT) ? w_rot_ptr : r_ptr;
    assign w_pick      = f_pick(req, w_pick_base);

    // State register and registered outputs; reset aborts any grant at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= w_valid_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: extend a burst, close it and re-arbitrate, or hold.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_valid;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_rearb     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_rearb = 1'b1;
                end
            end
            ST_GRANT: begin
                if (ack && w_cur_req && w_more) begin
                    w_cnt_nxt = r_cnt + WW'(1);
                end else if (ack || !w_cur_req) begin
                    // Burst complete or request withdrawn: rotate past holder.
                    w_ptr_nxt = w_rot_ptr;
                    w_cnt_nxt = '0;
                    w_rearb   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_rearb) begin
            if (w_pick[IW]) begin
                w_state_nxt = ST_GRANT;
                w_valid_nxt = 1'b1;
                w_idx_nxt   = w_pick[IW-1:0];
                w_grant_nxt = c_ONE << w_pick[IW-1:0];
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_idx_nxt   = '0;
                w_grant_nxt = '0;
            end
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wrr_arbiter
// Description : Self-checking bench for wrr_arbiter. A behavioural model
//               pushes expected outputs to a scoreboard queue each cycle;
//               they are popped and compared after the clock edge. A second
//               instance with N=3 covers wrap-around for non-power-of-two N.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wrr_arbiter;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;

    logic [3:0]  req4    = '0;
    logic [15:0] weight4 = 16'h1111;
    logic        ack4    = 1'b0;
    logic [3:0]  grant4;
    logic        gv4;
    logic [1:0]  gidx4;

    logic [2:0]  req3    = '0;
    logic [11:0] weight3 = 12'h111;
    logic        ack3    = 1'b0;
    logic [2:0]  grant3;
    logic        gv3;
    logic [1:0]  gidx3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] sb_q [$];

    bit         m_valid;
    logic [1:0] m_idx;
    logic [1:0] m_ptr;
    int         m_cnt;

    wrr_arbiter #(.N(4), .WW(4)) u_dut4 (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req4),
        .weight      (weight4),
        .ack         (ack4),
        .grant       (grant4),
        .grant_valid (gv4),
        .grant_idx   (gidx4)
    );

    wrr_arbiter #(.N(3), .WW(4)) u_dut3 (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req3),
        .weight      (weight3),
        .ack         (ack3),
        .grant       (grant3),
        .grant_valid (gv3),
        .grant_idx   (gidx3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_pick(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] j;
        for (int k = 0; k < 4; k++) begin
            j = p + 2'(k);
            if (v[j]) return int'(j);
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = '0;
        m_ptr   = '0;
        m_cnt   = 0;
        sb_q.delete();
    endtask

    // Advance the model by one clock using the inputs as currently driven.
    task automatic model_push();
        int         w;
        int         wt;
        logic [6:0] e;
        if (!m_valid) begin
            w = m_pick(req4, m_ptr);
            if (w >= 0) begin
                m_valid = 1'b1;
                m_idx   = 2'(w);
                m_cnt   = 0;
            end
        end else begin
            wt = int'(weight4[{m_idx, 2'b00} +: 4]);
            if (wt == 0) wt = 1;
            if (ack4 && req4[m_idx] && (m_cnt + 1 < wt)) begin
                m_cnt++;
            end else if (ack4 || !req4[m_idx]) begin
                m_ptr = m_idx + 2'd1;
                m_cnt = 0;
                w = m_pick(req4, m_ptr);
                if (w >= 0) begin
                    m_idx = 2'(w);
                end else begin
                    m_valid = 1'b0;
                    m_idx   = '0;
                end
            end
        end
        e[6]   = m_valid;
        e[5:4] = m_idx;
        e[3:0] = m_valid ? (4'b0001 << m_idx) : 4'b0000;
        sb_q.push_back(e);
    endtask

    task automatic step(input string tag);
        logic [6:0] e;
        logic [6:0] g;
        model_push();
        @(posedge clk);
        #1;
        g = {gv4, gidx4, grant4};
        e = sb_q.pop_front();
        check(tag, 32'(g), 32'(e));
    endtask

    task automatic reset_pulse();
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by a randomised scoreboard run.
    initial begin
        int         seq [8];
        logic [3:0] exp_g;
        seq = '{0, 0, 0, 1, 1, 2, 3, 0};

        // Reset holds outputs low even with all requests active.
        req4 = 4'b1111; weight4 = 16'h1111; ack4 = 1'b0;
        rstn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant4), 0);
        check("rst_valid", 32'(gv4), 0);
        check("rst_idx", 32'(gidx4), 0);
        rstn = 1'b1;
        step("first");
        check("first_grant", 32'(grant4), 32'h1);

        // Weight-1 round robin with ack every cycle.
        ack4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("rr");
            exp_g = 4'b0001 << ((i + 1) % 4);
            check("rr_grant", 32'(grant4), 32'(exp_g));
        end

        // Weighted bursts, then weight 0 on requester 2 behaving as 1.
        for (int pass = 0; pass < 2; pass++) begin
            weight4 = (pass == 0) ? {4'd1, 4'd1, 4'd2, 4'd3} : {4'd1, 4'd0, 4'd2, 4'd3};
            req4 = 4'b1111; ack4 = 1'b1;
            reset_pulse();
            for (int i = 0; i < 8; i++) begin
                step("wrr");
                check("wrr_idx", 32'(gidx4), 32'(seq[i]));
            end
        end

        // Grant held while ack is low; released when ack arrives and req drops.
        weight4 = 16'h1111; req4 = 4'b0100; ack4 = 1'b0;
        reset_pulse();
        step("hold_first");
        for (int i = 0; i < 5; i++) begin
            step("hold");
            check("hold_grant", 32'(grant4), 32'h4);
        end
        ack4 = 1'b1; req4 = 4'b0000;
        step("release");
        check("release_valid", 32'(gv4), 0);
        check("release_grant", 32'(grant4), 0);

        // Random traffic against the model, weights changed occasionally.
        reset_pulse();
        for (int i = 0; i < 300; i++) begin
            if (i % 40 == 0) weight4 = 16'($urandom);
            req4 = 4'($urandom);
            ack4 = 1'($urandom_range(0, 1));
            step("rand");
        end

        // Async reset in the middle of a weight-3 burst on requester 2.
        weight4 = {4'd1, 4'd3, 4'd1, 4'd1}; req4 = 4'b0101; ack4 = 1'b1;
        reset_pulse();
        step("ar_a");
        step("ar_b");
        step("ar_c");
        check("ar_mid_idx", 32'(gidx4), 2);
        #1;
        rstn = 1'b0;
        model_reset();
        #1;
        check("ar_grant", 32'(grant4), 0);
        check("ar_valid", 32'(gv4), 0);
        check("ar_idx", 32'(gidx4), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step("ar_restart");
        check("ar_restart_idx", 32'(gidx4), 0);

        // N=3: withdrawal on the last index wraps to 0; burst cut short rotates.
        req4 = 4'b0000; ack4 = 1'b0;
        req3 = 3'b111; weight3 = 12'h111; ack3 = 1'b1;
        reset_pulse();
        check("n3_rst_valid", 32'(gv3), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("n3_rr_idx", 32'(gidx3), 32'(i));
        end
        ack3 = 1'b0; req3 = 3'b011;
        @(posedge clk); #1;
        check("n3_wrap_idx", 32'(gidx3), 0);
        check("n3_wrap_grant", 32'(grant3), 32'h1);
        weight3 = {4'd1, 4'd1, 4'd3}; ack3 = 1'b1; req3 = 3'b011;
        @(posedge clk); #1;
        check("n3_burst_idx", 32'(gidx3), 0);
        req3 = 3'b110;
        @(posedge clk); #1;
        check("n3_cut_idx", 32'(gidx3), 1);
        check("n3_cut_valid", 32'(gv3), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
